// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one WIDTH-bit adder between NUM_REQ requesters.
// Each accepted operand pair produces one registered, id-tagged sum on the response port.
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH:0]             rsp_sum,
  output logic                       busy,
  output logic [15:0]                ops_done
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   grant_id;
  logic             grant_found;
  int               idx;

  // Search starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    req_ready   = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    if (state == IDLE && !reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last) + k) % NUM_REQ;
        if (!grant_found && req_valid[idx]) begin
          grant_found    = 1'b1;
          req_ready[idx] = 1'b1;
          grant_id       = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_found) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= IDW'(NUM_REQ - 1);
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      ops_done  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a  <= req_a[int'(grant_id)*WIDTH +: WIDTH];
            op_b  <= req_b[int'(grant_id)*WIDTH +: WIDTH];
            op_id <= grant_id;
            last  <= grant_id;
          end
        end
        EXEC: begin
          rsp_sum   <= {1'b0, op_a} + {1'b0, op_b};
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed, table-driven bench for adder_rr_scheduler: single operations from a vector table,
// then hand-written sequences for arbitration order, backpressure, reset mid-operation and counter wrap.
module tb_adder_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_sum;
  logic        busy;
  logic [15:0] ops_done;

  int compared   = 0;
  int mismatched = 0;
  int ops_exp    = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ready;
    logic [1:0]  id;
    logic [8:0]  sum;
  } vec_t;

  vec_t vecs[6];

  adder_rr_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_sum(rsp_sum),
    .busy(busy),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] a,
                               input logic [31:0] b, input logic rdy);
    req_valid = valid;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  initial begin
    vecs[0] = '{4'b0010, {8'd0, 8'd0, 8'd200, 8'd0}, {8'd0, 8'd0, 8'd100, 8'd0}, 4'b0010, 2'd1, 9'd300};
    vecs[1] = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0100, 2'd2, 9'd33};
    vecs[2] = '{4'b1001, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b1000, 2'd3, 9'd44};
    vecs[3] = '{4'b1001, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0001, 2'd0, 9'd11};
    vecs[4] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd255}, 4'b0001, 2'd0, 9'd510};
    vecs[5] = '{4'b0011, {8'd9, 8'd9, 8'd0, 8'd9}, {8'd9, 8'd9, 8'd0, 8'd9}, 4'b0010, 2'd1, 9'd0};

    // Reset with all requesters valid: nothing may be granted while reset is high.
    reset = 1'b1;
    applyStimulus(4'b1111, 32'h0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ops_done", 32'(ops_done), 32'd0);
    reset = 1'b0;
    applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1);
    checkOutput("idle_no_valid_ready", 32'(req_ready), 32'd0);
    tick();
    checkOutput("idle_stays_idle", 32'(busy), 32'd0);

    // Table: one complete operation per vector, pointer carried across vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, 1'b1);
      checkOutput($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      tick();
      req_valid = 4'b0000;
      checkOutput($sformatf("vec%0d_busy_exec", i), 32'(busy), 32'd1);
      checkOutput($sformatf("vec%0d_exec_rsp_valid", i), 32'(rsp_valid), 32'd0);
      tick();
      checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].id));
      checkOutput($sformatf("vec%0d_rsp_sum", i), 32'(rsp_sum), 32'(vecs[i].sum));
      tick();
      ops_exp++;
      checkOutput($sformatf("vec%0d_rsp_done", i), 32'(rsp_valid), 32'd0);
      checkOutput($sformatf("vec%0d_ops_done", i), 32'(ops_done), 32'(ops_exp));
    end

    // All requesters held valid after reset: grants rotate 0,1,2,3,0 every 3 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ops_exp = 0;
    applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      checkOutput($sformatf("rr%0d_exec_ready", k), 32'(req_ready), 32'd0);
      tick();
      checkOutput($sformatf("rr%0d_resp_ready", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(k % 4));
      checkOutput($sformatf("rr%0d_rsp_sum", k), 32'(rsp_sum), 32'(11 * ((k % 4) + 1)));
      tick();
      ops_exp++;
      checkOutput($sformatf("rr%0d_ops_done", k), 32'(ops_done), 32'(ops_exp));
    end

    // Backpressure: response held stable for 5 cycles; operand changes after handshake ignored.
    applyStimulus(4'b0100, {8'd0, 8'd7, 8'd0, 8'd0}, {8'd0, 8'd9, 8'd0, 8'd0}, 1'b0);
    checkOutput("bp_grant", 32'(req_ready), 32'b0100);
    tick();
    req_a = {8'd0, 8'd100, 8'd0, 8'd0};
    req_b = {8'd0, 8'd100, 8'd0, 8'd0};
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d_rsp_id", k), 32'(rsp_id), 32'd2);
      checkOutput($sformatf("bp%0d_rsp_sum", k), 32'(rsp_sum), 32'd16);
      checkOutput($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("bp%0d_ops_done", k), 32'(ops_done), 32'(ops_exp));
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();
    ops_exp++;
    checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_release_ops_done", 32'(ops_done), 32'(ops_exp));

    // Reset during EXEC drops the transaction and restores the pointer.
    applyStimulus(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, {8'd0, 8'd5, 8'd0, 8'd0}, 1'b1);
    checkOutput("rst_mid_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_mid%0d_rsp_valid", k), 32'(rsp_valid), 32'd0);
      tick();
    end
    checkOutput("rst_mid_ops_done", 32'(ops_done), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0101, 32'h0, 32'h0, 1'b1);
    checkOutput("rst_mid_ptr_grant", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    #1;

    // Counter wrap from 0xFFFF to 0.
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    #1;
    checkOutput("wrap_preload", 32'(ops_done), 32'hFFFF);
    applyStimulus(4'b0001, {24'd0, 8'd255}, {24'd0, 8'd255}, 1'b1);
    tick();
    req_valid = 4'b0000;
    tick();
    checkOutput("wrap_sum", 32'(rsp_sum), 32'h1FE);
    tick();
    checkOutput("wrap_ops_done", 32'(ops_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
